wfg_core_timing_sequencer: RTL and testbench

Timing sequencer for the waveform-generator core. It turns the core's configuration registers into free-running timing strobes: CTRL.EN, CFG.SUBCYCLE and CFG.SYNC. The strobes are a subcycle tick and a frame-start (sync) pulse, and downstream stimulus and driver blocks schedule their work against them. It sits between the core's Wishbone register file and every wfg peripheral that consumes core timing. It shadows the configuration so that register writes never corrupt a frame in progress.

---
 rtl/wfg_core_timing_sequencer.sv | 112 +++++++++++
 tb/tb_wfg_core_timing_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wfg_core_timing_sequencer.sv
// wfg_core_timing_sequencer
// Turns the core configuration (CTRL.EN, CFG.SUBCYCLE, CFG.SYNC) into
// free-running subcycle and frame-start strobes. The configuration is
// shadowed and only reloaded at frame boundaries, so a register write
// can never stretch or shorten a frame that is already running.
// All outputs come straight from flops, which are loaded from the decoded
// next state. The strobes therefore look exactly like a decode of the
// counters, with no combinational path from the inputs.

module wfg_core_timing_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ctrl_en_q_i,
  input  logic [15:0] cfg_subcycle_q_i,
  input  logic [7:0]  cfg_sync_q_i,
  output logic        wfg_core_subcycle_o,
  output logic        wfg_core_start_o,
  output logic [7:0]  wfg_core_subcycle_cnt_o,
  output logic        active_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]  state_r;
  logic [0:0]  state_s;
  logic [15:0] presc_q;
  logic [15:0] presc_s;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_s;
  logic [15:0] sub_sh;
  logic [15:0] sub_s;
  logic [7:0]  sync_sh;
  logic [7:0]  sync_s;
  logic        run_s;

  // Next-state logic: prescaler counts clocks within a subcycle, cnt counts
  // subcycles within a frame, and the shadows reload only when a frame wraps.
  always_comb begin
    state_s = state_r;
    presc_s = presc_q;
    cnt_s   = cnt_q;
    sub_s   = sub_sh;
    sync_s  = sync_sh;
    case (state_r)
      ST_IDLE: begin
        presc_s = 16'd0;
        cnt_s   = 8'd0;
        if (ctrl_en_q_i) begin
          state_s = ST_RUN;
          sub_s   = cfg_subcycle_q_i;
          sync_s  = cfg_sync_q_i;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!ctrl_en_q_i) begin
          // Disabling abandons the partial frame immediately.
          state_s = ST_IDLE;
          presc_s = 16'd0;
          cnt_s   = 8'd0;
        end else if (presc_q != sub_sh) begin
          presc_s = presc_q + 16'd1;
        end else begin
          presc_s = 16'd0;
          if (cnt_q != sync_sh) begin
            cnt_s = cnt_q + 8'd1;
          end else begin
            // Frame boundary: the only point where new configuration is taken.
            cnt_s  = 8'd0;
            sub_s  = cfg_subcycle_q_i;
            sync_s = cfg_sync_q_i;
          end
        end
      end
      default: begin
        state_s = ST_IDLE;
        presc_s = 16'd0;
        cnt_s   = 8'd0;
      end
    endcase
  end

  assign run_s = (state_s == ST_RUN);

  // State, counters, shadows and registered strobe outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r                 <= ST_IDLE;
      presc_q                 <= 16'd0;
      cnt_q                   <= 8'd0;
      sub_sh                  <= 16'd0;
      sync_sh                 <= 8'd0;
      wfg_core_subcycle_o     <= 1'b0;
      wfg_core_start_o        <= 1'b0;
      wfg_core_subcycle_cnt_o <= 8'd0;
      active_o                <= 1'b0;
    end else begin
      state_r                 <= state_s;
      presc_q                 <= presc_s;
      cnt_q                   <= cnt_s;
      sub_sh                  <= sub_s;
      sync_sh                 <= sync_s;
      wfg_core_subcycle_o     <= run_s && (presc_s == 16'd0);
      wfg_core_start_o        <= run_s && (presc_s == 16'd0) && (cnt_s == 8'd0);
      wfg_core_subcycle_cnt_o <= run_s ? cnt_s : 8'd0;
      active_o                <= run_s;
    end
  end

endmodule

// File: tb/tb_wfg_core_timing_sequencer.sv
// Self-checking bench for wfg_core_timing_sequencer. A behavioural model
// predicts each cycle's outputs and queues them when the stimulus for an
// edge is applied. The test tasks pop the queue after the edge and compare.
// They also check cadence directly against closed-form expectations.

module tb_wfg_core_timing_sequencer;

  logic        clk;
  logic        rst_n;
  logic        ctrl_en;
  logic [15:0] cfg_sub;
  logic [7:0]  cfg_sync;
  logic        sub_o;
  logic        start_o;
  logic [7:0]  cnt_o;
  logic        act_o;

  typedef struct packed {
    logic       sub;
    logic       start;
    logic [7:0] cnt;
    logic       act;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // reference model state
  logic        m_run;
  logic [31:0] m_p;
  logic [31:0] m_c;
  logic [31:0] m_sub;
  logic [31:0] m_sync;

  wfg_core_timing_sequencer dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .ctrl_en_q_i             (ctrl_en),
    .cfg_subcycle_q_i        (cfg_sub),
    .cfg_sync_q_i            (cfg_sync),
    .wfg_core_subcycle_o     (sub_o),
    .wfg_core_start_o        (start_o),
    .wfg_core_subcycle_cnt_o (cnt_o),
    .active_o                (act_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_run = 1'b0;
    m_p = 0;
    m_c = 0;
    m_sub = 0;
    m_sync = 0;
  endtask

  // Apply inputs away from the edge, predict the edge, wait until just after it.
  task automatic tick(input logic en, input logic [15:0] sub, input logic [7:0] sync);
    exp_t e;
    ctrl_en  = en;
    cfg_sub  = sub;
    cfg_sync = sync;
    if (!m_run) begin
      if (en) begin
        m_run = 1'b1;
        m_sub = {16'd0, sub};
        m_sync = {24'd0, sync};
        m_p = 0;
        m_c = 0;
      end
    end else if (!en) begin
      m_run = 1'b0;
      m_p = 0;
      m_c = 0;
    end else if (m_p < m_sub) begin
      m_p = m_p + 1;
    end else begin
      m_p = 0;
      if (m_c < m_sync) begin
        m_c = m_c + 1;
      end else begin
        m_c = 0;
        m_sub = {16'd0, sub};
        m_sync = {24'd0, sync};
      end
    end
    e.sub   = m_run && (m_p == 0);
    e.start = m_run && (m_p == 0) && (m_c == 0);
    e.cnt   = m_run ? m_c[7:0] : 8'd0;
    e.act   = m_run;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t got;
    rst_n = 1'b0;
    ctrl_en = 1'b0;
    cfg_sub = 16'd0;
    cfg_sync = 8'd0;
    model_reset();
    #12;
    got = {sub_o, start_o, cnt_o, act_o};
    checks++;
    if (got !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 000", got);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b0, 16'd3, 8'd2);
    got = {sub_o, start_o, cnt_o, act_o};
    checks++;
    if (got !== exp_q.pop_front()) begin
      errors++;
      $display("FAIL idle_after_reset: got %h expected 000", got);
    end
  endtask

  task automatic test_basic_cadence();
    exp_t got;
    exp_t e;
    logic [7:0] cnt_tab [13];
    cnt_tab = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd2, 8'd0};
    for (int i = 0; i < 26; i++) begin
      tick(1'b1, 16'd3, 8'd2);
      got = {sub_o, start_o, cnt_o, act_o};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL basic_sb[%0d]: got %h expected %h", i, got, e);
      end
      checks++;
      if (sub_o !== (i % 4 == 0) || start_o !== (i % 12 == 0) || act_o !== 1'b1) begin
        errors++;
        $display("FAIL basic_cadence[%0d]: sub %b start %b act %b", i, sub_o, start_o, act_o);
      end
      if (i < 13) begin
        checks++;
        if (cnt_o !== cnt_tab[i]) begin
          errors++;
          $display("FAIL basic_cnt[%0d]: got %0d expected %0d", i, cnt_o, cnt_tab[i]);
        end
      end
    end
    tick(1'b0, 16'd3, 8'd2);
    got = {sub_o, start_o, cnt_o, act_o};
    e = exp_q.pop_front();
    checks++;
    if (got !== e || got !== 11'd0) begin
      errors++;
      $display("FAIL basic_disable: got %h expected 000", got);
    end
  endtask

  task automatic test_reconfig();
    exp_t got;
    exp_t e;
    logic [15:0] sub;
    logic exp_start;
    logic exp_sub;
    sub = 16'd3;
    for (int i = 0; i < 26; i++) begin
      if (i == 5) sub = 16'd1;
      tick(1'b1, sub, 8'd2);
      got = {sub_o, start_o, cnt_o, act_o};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reconfig_sb[%0d]: got %h expected %h", i, got, e);
      end
      exp_start = (i == 0) || (i == 12) || (i == 18) || (i == 24);
      exp_sub   = (i < 12) ? (i % 4 == 0) : (i % 2 == 0);
      checks++;
      if (start_o !== exp_start || sub_o !== exp_sub) begin
        errors++;
        $display("FAIL reconfig_cadence[%0d]: start %b/%b sub %b/%b", i, start_o, exp_start, sub_o, exp_sub);
      end
    end
    tick(1'b0, 16'd1, 8'd2);
    void'(exp_q.pop_front());
  endtask

  task automatic test_degenerate();
    exp_t got;
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 16'd0, 8'd0);
      got = {sub_o, start_o, cnt_o, act_o};
      e = exp_q.pop_front();
      checks++;
      if (got !== e || got !== {1'b1, 1'b1, 8'd0, 1'b1}) begin
        errors++;
        $display("FAIL degen_00[%0d]: got %h expected %h", i, got, e);
      end
    end
    tick(1'b0, 16'd0, 8'd3);
    void'(exp_q.pop_front());
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, 16'd0, 8'd3);
      got = {sub_o, start_o, cnt_o, act_o};
      e = exp_q.pop_front();
      checks++;
      if (got !== e || got !== {1'b1, (i % 4 == 0), 8'(i % 4), 1'b1}) begin
        errors++;
        $display("FAIL degen_03[%0d]: got %h expected %h", i, got, e);
      end
    end
    tick(1'b0, 16'd0, 8'd3);
    void'(exp_q.pop_front());
  endtask

  task automatic test_disable_reenable();
    exp_t got;
    exp_t e;
    // enable edge gives cnt0/presc0; after 6 more edges cnt=1, presc=2
    for (int i = 0; i < 7; i++) begin
      tick(1'b1, 16'd3, 8'd2);
      e = exp_q.pop_front();
      got = {sub_o, start_o, cnt_o, act_o};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL dis_run[%0d]: got %h expected %h", i, got, e);
      end
    end
    checks++;
    if (cnt_o !== 8'd1 || sub_o !== 1'b0) begin
      errors++;
      $display("FAIL dis_position: cnt %0d expected 1, sub %b expected 0", cnt_o, sub_o);
    end
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 16'd3, 8'd2);
      e = exp_q.pop_front();
      got = {sub_o, start_o, cnt_o, act_o};
      checks++;
      if (got !== e || got !== 11'd0) begin
        errors++;
        $display("FAIL dis_off[%0d]: got %h expected 000", i, got);
      end
    end
    tick(1'b1, 16'd3, 8'd2);
    e = exp_q.pop_front();
    got = {sub_o, start_o, cnt_o, act_o};
    checks++;
    if (got !== e || got !== {1'b1, 1'b1, 8'd0, 1'b1}) begin
      errors++;
      $display("FAIL reenable: got %h expected %h", got, e);
    end
  endtask

  task automatic test_async_reset();
    exp_t got;
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 16'd3, 8'd2);
      void'(exp_q.pop_front());
    end
    checks++;
    if (act_o !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre: active %b expected 1", act_o);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    got = {sub_o, start_o, cnt_o, act_o};
    checks++;
    if (got !== 11'd0) begin
      errors++;
      $display("FAIL arst_async: got %h expected 000", got);
    end
    rst_n = 1'b1;
    tick(1'b1, 16'd3, 8'd2);
    e = exp_q.pop_front();
    got = {sub_o, start_o, cnt_o, act_o};
    checks++;
    if (got !== e || got !== {1'b1, 1'b1, 8'd0, 1'b1}) begin
      errors++;
      $display("FAIL arst_restart: got %h expected %h", got, e);
    end
    tick(1'b0, 16'd3, 8'd2);
    void'(exp_q.pop_front());
  endtask

  task automatic test_max();
    exp_t got;
    exp_t e;
    logic [7:0] ec;
    for (int i = 0; i <= 65536; i++) begin
      tick(1'b1, 16'hFFFF, 8'h01);
      got = {sub_o, start_o, cnt_o, act_o};
      e = exp_q.pop_front();
      ec = (i >= 65536) ? 8'd1 : 8'd0;
      checks++;
      if (got !== e || got !== {(i == 0 || i == 65536), (i == 0), ec, 1'b1}) begin
        errors++;
        $display("FAIL max[%0d]: got %h expected %h", i, got, e);
      end
    end
    tick(1'b0, 16'hFFFF, 8'h01);
    void'(exp_q.pop_front());
  endtask

  initial begin
    test_reset();
    test_basic_cadence();
    test_reconfig();
    test_degenerate();
    test_disable_reenable();
    test_async_reset();
    test_max();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
